elevator_car_ctrl: RTL and testbench

- Consumer side of the floor-request latch: reads the latched pending-request vector and its non-empty flag, and moves the car one floor at a time using collective (SCAN) scheduling.
- On arrival at a requested floor it opens the door and returns a one-cycle one-hot clear pulse to the request latch.
- Sits between the request latch and the car position/door display logic.

---
 rtl/elevator_car_ctrl.sv | 179 +++++++++++++++++
 tb/tb_elevator_car_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl
//   Car controller that consumes the latched floor-request vector and moves
//   the car one floor at a time with collective (SCAN) scheduling. When the
//   car reaches a requested floor it opens the door and returns a one-cycle,
//   one-hot clear pulse to the request latch.
//
//   Optional feature macro: ELEVATOR_ESTOP_EN (adds the estop input).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   estop      (ELEVATOR_ESTOP_EN only) freeze timers/departures, mute clr
//   req        pending requests from the latch, bit i = floor i
//   req_flag   "any request" qualifier; low masks req completely
//   clr        one-hot clear pulse back to the latch
//   floor      current car floor
//   dir_up     current/last travel direction (1 = up)
//   moving     high while travelling between floors
//   door_open  high while the door is open
module elevator_car_ctrl #(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                      estop,
`endif
  input  logic [FLOORS-1:0]         req,
  input  logic                      req_flag,
  output logic [FLOORS-1:0]         clr,
  output logic [$clog2(FLOORS)-1:0] floor,
  output logic                      dir_up,
  output logic                      moving,
  output logic                      door_open
);

  localparam int FW = $clog2(FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, DOOR = 2'd2} state_t;

  state_t            state, state_n;
  logic [FW-1:0]     floor_n, nf;
  logic              dir_n;
  logic [FLOORS-1:0] clr_q, clr_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [DW-1:0]     dcnt, dcnt_n;
  logic [FLOORS-1:0] live;
  logic              here, above, below, at_end, freeze;

`ifdef ELEVATOR_ESTOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (v[i] && (i > int'(f))) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (v[i] && (i < int'(f))) r = 1'b1;
    return r;
  endfunction

  function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [FLOORS-1:0] r;
    r = '0;
    r[f] = 1'b1;
    return r;
  endfunction

  // req_flag low means the vector may be stale: treat it as empty.
  assign live  = req & {FLOORS{req_flag}};
  assign here  = live[floor];
  assign above = any_above(live, floor);
  assign below = any_below(live, floor);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      floor  <= '0;
      dir_up <= 1'b1;
      clr_q  <= '0;
      tcnt   <= '0;
      dcnt   <= '0;
    end else begin
      state  <= state_n;
      floor  <= floor_n;
      dir_up <= dir_n;
      clr_q  <= clr_n;
      tcnt   <= tcnt_n;
      dcnt   <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    floor_n = floor;
    dir_n   = dir_up;
    clr_n   = '0;
    tcnt_n  = tcnt;
    dcnt_n  = dcnt;
    nf      = dir_up ? floor + FW'(1) : floor - FW'(1);
    at_end  = dir_up ? (floor == FW'(FLOORS - 1)) : (floor == '0);
    // While frozen everything holds and clr_n stays 0.
    if (!freeze) begin
      unique case (state)
        IDLE: begin
          tcnt_n = '0;
          dcnt_n = '0;
          if (here) begin
            state_n = DOOR;
            clr_n   = onehot(floor);
          end else if (dir_up && above) begin
            state_n = MOVING;
          end else if (!dir_up && below) begin
            state_n = MOVING;
          end else if (above) begin
            state_n = MOVING;
            dir_n   = 1'b1;
          end else if (below) begin
            state_n = MOVING;
            dir_n   = 1'b0;
          end
        end
        MOVING: begin
          if (tcnt == TW'(TRAVEL_CYCLES - 1)) begin
            tcnt_n = '0;
            if (at_end) begin
              // Unreachable in normal operation; keeps floor from wrapping.
              state_n = IDLE;
            end else begin
              // Arrival is judged against the floor we are stepping onto.
              floor_n = nf;
              if (live[nf]) begin
                state_n = DOOR;
                clr_n   = onehot(nf);
                dcnt_n  = '0;
              end else if (!(dir_up ? any_above(live, nf) : any_below(live, nf))) begin
                state_n = IDLE;
              end
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        DOOR: begin
          // A request for this floor while no clear is in flight is a fresh
          // press (the previous clear has already emptied the latch bit):
          // service it and restart the door timer.
          if (here && (clr_q == '0)) begin
            clr_n  = onehot(floor);
            dcnt_n = '0;
          end else if (dcnt == DW'(DOOR_CYCLES - 1)) begin
            state_n = IDLE;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign clr       = clr_q & ~{FLOORS{freeze}};
  assign moving    = (state == MOVING);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl
//   Drives elevator_car_ctrl (FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3) with a
//   small request-latch model and compares every cycle against a countdown
//   based reference of the car (position, travel time left, door time left).
module tb_elevator_car_ctrl;
  localparam int F  = 8;
  localparam int TC = 4;
  localparam int DC = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         estop = 1'b0;
  logic         kill = 1'b0;
  logic [F-1:0] press = '0;
  logic [F-1:0] drop = '0;
  logic [F-1:0] req;
  logic         req_flag;
  logic [F-1:0] clr;
  logic [2:0]   floor;
  logic         dir_up, moving, door_open;

  int errors = 0;
  int checks = 0;

  // reference model state
  int         m_pos, m_tl, m_dl;
  bit         m_up;
  logic [F-1:0] m_clr;

  logic [13:0] obs, expv;
  localparam logic [13:0] RST_V = {8'h00, 3'd0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  elevator_car_ctrl #(.FLOORS(F), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .req(req),
    .req_flag(req_flag),
    .clr(clr),
    .floor(floor),
    .dir_up(dir_up),
    .moving(moving),
    .door_open(door_open)
  );

  // request latch: set by presses, then cleared by clr in the same cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) req <= '0;
    else        req <= ((req | press) & ~clr) & ~drop;

  assign req_flag = (|req) & ~kill;
  assign obs  = {clr, floor, dir_up, moving, door_open};
  assign expv = {m_clr & ~{F{estop}}, 3'(m_pos), m_up, (m_tl > 0), (m_dl > 0)};

  function automatic bit ahead(input logic [F-1:0] v, input int p, input bit up);
    for (int i = 0; i < F; i++)
      if (v[i] && (up ? (i > p) : (i < p))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_up = 1'b1; m_tl = 0; m_dl = 0; m_clr = '0;
  endtask

  // One clock of the reference: door time and travel time count down to 0.
  task automatic model_step();
    logic [F-1:0] lv;
    bit ab, be;
    lv = req & {F{req_flag}};
    if (estop) begin
      m_clr = '0;
    end else if (m_dl > 0) begin
      if (lv[m_pos] && m_clr == '0) begin
        m_clr = F'(1 << m_pos);
        m_dl  = DC;
      end else begin
        m_clr = '0;
        m_dl--;
      end
    end else if (m_tl > 0) begin
      m_clr = '0;
      m_tl--;
      if (m_tl == 0) begin
        m_pos += m_up ? 1 : -1;
        if (lv[m_pos]) begin
          m_clr = F'(1 << m_pos);
          m_dl  = DC;
        end else if (ahead(lv, m_pos, m_up)) begin
          m_tl = TC;
        end
      end
    end else begin
      m_clr = '0;
      ab = ahead(lv, m_pos, 1'b1);
      be = ahead(lv, m_pos, 1'b0);
      if (lv[m_pos]) begin
        m_clr = F'(1 << m_pos);
        m_dl  = DC;
      end else if (ab && (m_up || !be)) begin
        m_up = 1'b1; m_tl = TC;
      end else if (be) begin
        m_up = 1'b0; m_tl = TC;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    press = '0;
    drop  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== RST_V) begin errors++; $display("FAIL reset_hold got=%h want=%h", obs, RST_V); end
    reset = 1'b1;
    repeat (6) begin
      tick();
      checks++;
      if (obs !== RST_V) begin errors++; $display("FAIL reset_idle got=%h want=%h", obs, RST_V); end
    end
  endtask

  task automatic test_single_trip();
    int n = 0;
    logic [F-1:0] seen = '0;
    press = 8'h08;
    repeat (30) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL trip got=%h want=%h", obs, expv); end
      if (clr != '0) begin n++; seen |= clr; end
    end
    checks++;
    if (n != 1 || seen !== 8'h08) begin errors++; $display("FAIL trip_clr got=%0d pulses of %h want 1 of 08", n, seen); end
    checks++;
    if (floor !== 3'd3 || moving || door_open) begin errors++; $display("FAIL trip_end got floor=%0d want 3 idle", floor); end
  endtask

  task automatic test_scan_reverse();
    int n = 0;
    logic [F-1:0] first = '0, second = '0;
    press = 8'h41;
    repeat (60) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL scan got=%h want=%h", obs, expv); end
      if (clr != '0) begin
        if (n == 0) first = clr; else if (n == 1) second = clr;
        n++;
      end
    end
    checks++;
    if (n != 2 || first !== 8'h40 || second !== 8'h01) begin
      errors++; $display("FAIL scan_order got=%0d pulses %h,%h want 2 pulses 40,01", n, first, second);
    end
    checks++;
    if (floor !== 3'd0 || dir_up !== 1'b0) begin errors++; $display("FAIL scan_end got floor=%0d up=%b want 0,0", floor, dir_up); end
  endtask

  task automatic test_door_reopen();
    int n = 0, mv = 0, dr = 0;
    press = 8'h01;
    repeat (3) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reopen got=%h want=%h", obs, expv); end
      if (clr != '0) n++;
      if (moving) mv++;
      if (door_open) dr++;
    end
    press = 8'h01;
    repeat (10) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reopen got=%h want=%h", obs, expv); end
      if (clr != '0) n++;
      if (moving) mv++;
      if (door_open) dr++;
    end
    checks++;
    if (n != 2 || mv != 0 || dr != 6) begin
      errors++; $display("FAIL reopen_sum got pulses=%0d moves=%0d door=%0d want 2,0,6", n, mv, dr);
    end
  endtask

  task automatic test_withdraw();
    bit dropped = 1'b0;
    int n = 0;
    press = 8'h20;
    repeat (40) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL withdraw got=%h want=%h", obs, expv); end
      if (clr != '0) n++;
      if (!dropped && floor == 3'd4 && moving) begin drop = 8'h20; dropped = 1'b1; end
    end
    checks++;
    if (!dropped || n != 0 || floor !== 3'd5 || moving || door_open) begin
      errors++; $display("FAIL withdraw_end got dropped=%0d pulses=%0d floor=%0d want 1,0,5", dropped, n, floor);
    end
  endtask

  task automatic test_flag_guard();
    int n = 0;
    kill  = 1'b1;
    press = 8'hA0;
    repeat (8) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL flag_low got=%h want=%h", obs, expv); end
    end
    checks++;
    if (floor !== 3'd5 || moving || door_open || clr != '0) begin
      errors++; $display("FAIL flag_hold got=%h want floor 5 idle", obs);
    end
    kill = 1'b0;
    repeat (40) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL flag_rel got=%h want=%h", obs, expv); end
      if (clr != '0) n++;
    end
    checks++;
    if (n != 2 || floor !== 3'd7) begin errors++; $display("FAIL flag_end got pulses=%0d floor=%0d want 2,7", n, floor); end
  endtask

`ifdef ELEVATOR_ESTOP_EN
  task automatic test_estop();
    logic [2:0] snap;
    press = 8'h01;
    repeat (7) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL estop_pre got=%h want=%h", obs, expv); end
    end
    snap  = floor;
    estop = 1'b1;
    repeat (10) begin
      tick();
      checks++;
      if (obs !== expv || floor !== snap || !moving) begin
        errors++; $display("FAIL estop_hold got=%h want=%h floor %0d", obs, expv, snap);
      end
    end
    estop = 1'b0;
    repeat (40) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL estop_post got=%h want=%h", obs, expv); end
    end
    checks++;
    if (floor !== 3'd0) begin errors++; $display("FAIL estop_end got floor=%0d want 0", floor); end
    press = 8'h80;
    repeat (8) tick();
    estop = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== RST_V) begin errors++; $display("FAIL estop_reset got=%h want=%h", obs, RST_V); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    estop = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL estop_rel got=%h want=%h", obs, expv); end
    end
  endtask
`endif

  task automatic test_random();
    repeat (800) begin
      if ($urandom_range(0, 5) == 0) press = F'(1 << $urandom_range(0, F - 1));
      kill = ($urandom_range(0, 19) == 0);
`ifdef ELEVATOR_ESTOP_EN
      estop = ($urandom_range(0, 15) == 0);
`endif
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random got=%h want=%h", obs, expv); end
    end
    kill  = 1'b0;
    estop = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_single_trip();
    test_scan_reverse();
    test_door_reopen();
    test_withdraw();
    test_flag_guard();
`ifdef ELEVATOR_ESTOP_EN
    test_estop();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
